blk_alloc_client: RTL and testbench
===================================

Name: blk_alloc_client

Overview:
- Requester-side agent for the block memory manager, sitting in each ingress write port.
- Keeps a small prefetch pool of free block addresses. It runs the occupy handshake (`ocp_req` / `ocp_rsp` / `ocp_vld` / `ocp_block_addr`) against the manager and serves addresses to the write path with zero wait.
- Merges two release sources through a release queue and drives the manager's release interface (`rls_vld` / `rls_block_addr`) at one address per cycle.

Parameters:
- `AWIDTH`, 10, block address width; must match the manager.
- `POOL_DEPTH`, 4, prefetch pool entries; power of 2, at least 2.
- `REL_DEPTH`, 8, release queue entries; power of 2, at least 2.

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset
- `en`  in  1  prefetch enable; 0 blocks new occupy requests only
- `mgr_full`  in  1  manager full flag
- `ocp_req`  out  1  occupy request to manager
- `ocp_rsp`  in  1  manager response strobe
- `ocp_vld`  in  1  manager address-valid strobe
- `ocp_block_addr`  in  AWIDTH  allocated block address
- `blk_vld`  out  1  pool non-empty
- `blk_addr`  out  AWIDTH  pool head address (show-ahead)
- `blk_pop`  in  1  consume head address
- `pool_cnt`  out  log2(POOL_DEPTH)+1  pool occupancy
- `rel_push_a`  in  1  release request, source A (read path)
- `rel_addr_a`  in  AWIDTH  release address A
- `rel_push_b`  in  1  release request, source B (drop path)
- `rel_addr_b`  in  AWIDTH  release address B
- `rel_ready`  out  1  queue has at least 2 free entries
- `rls_vld`  out  1  release strobe to manager
- `rls_block_addr`  out  AWIDTH  release address to manager
- `rel_ovf`  out  1  sticky: a release push was dropped

Behaviour:
- Reset (`rst`=1 at a clk edge) clears all state.
  - Outputs next cycle: `ocp_req`=0, `blk_vld`=0, `blk_addr`=0, `pool_cnt`=0, `rls_vld`=0, `rls_block_addr`=0, `rel_ovf`=0, `rel_ready`=1.
  - Pool and queue are emptied and the FSM returns to IDLE.
  - Reset during WAIT abandons the outstanding grant. The manager is reset on the same `rst` domain, so no block leaks.
- Occupy FSM states: IDLE, REQ. At most one request is outstanding.
  - IDLE -> REQ when `en` && !`mgr_full` && `pool_cnt` < POOL_DEPTH. `ocp_req` is registered high on entry.
  - REQ holds `ocp_req`=1 until `ocp_vld`=1 is sampled. That cycle captures `ocp_block_addr` into the pool tail, then REQ -> IDLE with `ocp_req`=0 next cycle.
  - `ocp_req` is therefore low for at least 1 cycle between grants, so the manager never sees a stale request.
  - `ocp_rsp` is only sanity-checked: `ocp_vld` without `ocp_rsp` is still captured.
  - `mgr_full` or `en` dropping while in REQ does not withdraw the request; `ocp_req` is held until the grant.
  - `ocp_vld` sampled in IDLE is ignored (no capture).
- Pool (FIFO):
  - `blk_vld` = (`pool_cnt` != 0); `blk_addr` = head entry, or 0 when empty.
  - A captured address is visible on `blk_addr` the cycle after capture; there is no same-cycle bypass.
  - `blk_pop` while empty is ignored.
  - Capture and pop in the same cycle leave `pool_cnt` unchanged.
  - Pointers wrap modulo POOL_DEPTH.
  - The REQ entry condition guarantees a capture never overflows the pool.
- Release queue (FIFO):
  - Each cycle accepts up to 2 pushes, A then B in FIFO order (A precedes B when both are set).
  - Each cycle drains 1 entry: `rls_vld`/`rls_block_addr` are registered from the head, so latency push-to-`rls_vld` is 1 cycle when the queue is empty.
  - A pushed entry is drainable the same cycle it is written only via the registered output path; there is no combinational path from `rel_push` to `rls_vld`.
  - `rls_vld` is low whenever the queue is empty.
  - Overflow: if free entries are fewer than the pushes, A is accepted first if space allows and the excess push is dropped. `rel_ovf` is set and held until `rst`.
  - Free-entry count includes the entry being drained that cycle.

Test Plan:
- Reset, `en`=1, model manager grants 5,6,7,8 (2-cycle OCP latency) -> four `ocp_req` pulses separated by at least 1 low cycle; `pool_cnt`=4; `blk_addr`=5; `ocp_req` stays 0 thereafter.
- Pool full (5..8), `blk_pop` two cycles -> `blk_addr` 5->6->7, `pool_cnt` 3 then 2; new `ocp_req` rises the cycle after the first pop.
- `mgr_full`=1 with empty pool -> `ocp_req` stays 0, `blk_vld`=0. Release `mgr_full` -> `ocp_req` rises next cycle; grant 12 -> `blk_addr`=12, `blk_vld`=1.
- `rel_push_a`=3 and `rel_push_b`=9 in the same cycle, then `rel_push_a`=4 -> `rls_vld` for 3 consecutive cycles with addresses 3, 9, 4; `rel_ovf`=0.
- REL_DEPTH=8, dual pushes for 8 consecutive cycles -> queue saturates; excess B pushes are dropped, `rel_ovf`=1, `rel_ready`=0. Drained order is exactly the accepted pushes.
- `rst` asserted while in REQ with `pool_cnt`=2 -> next cycle `ocp_req`=0, `pool_cnt`=0, `blk_vld`=0, `rls_vld`=0. After release, prefetch restarts from an empty pool.

Source files
------------

// File: rtl/blk_alloc_client_if.sv
// Port bundle between the block-allocation client and its environment.
// master = the client itself, slave = write path / release sources / manager.
interface blk_alloc_client_if #(
    parameter int AWIDTH     = 10,
    parameter int POOL_DEPTH = 4
);
    localparam int PCW = $clog2(POOL_DEPTH) + 1;

    logic              en;
    logic              mgr_full;
    logic              ocp_req;
    logic              ocp_rsp;
    logic              ocp_vld;
    logic [AWIDTH-1:0] ocp_block_addr;
    logic              blk_vld;
    logic [AWIDTH-1:0] blk_addr;
    logic              blk_pop;
    logic [PCW-1:0]    pool_cnt;
    logic              rel_push_a;
    logic [AWIDTH-1:0] rel_addr_a;
    logic              rel_push_b;
    logic [AWIDTH-1:0] rel_addr_b;
    logic              rel_ready;
    logic              rls_vld;
    logic [AWIDTH-1:0] rls_block_addr;
    logic              rel_ovf;

    modport master (
        input  en, mgr_full, ocp_rsp, ocp_vld, ocp_block_addr, blk_pop,
               rel_push_a, rel_addr_a, rel_push_b, rel_addr_b,
        output ocp_req, blk_vld, blk_addr, pool_cnt, rel_ready,
               rls_vld, rls_block_addr, rel_ovf
    );

    modport slave (
        output en, mgr_full, ocp_rsp, ocp_vld, ocp_block_addr, blk_pop,
               rel_push_a, rel_addr_a, rel_push_b, rel_addr_b,
        input  ocp_req, blk_vld, blk_addr, pool_cnt, rel_ready,
               rls_vld, rls_block_addr, rel_ovf
    );
endinterface

// File: rtl/blk_alloc_client.sv
// Block-manager client: prefetch pool fed by a one-outstanding occupy FSM, plus a 2-in/1-out release queue.
// Pool head is served with zero wait; releases reach the manager 1 cycle after push; pushes beyond free space are dropped (sticky rel_ovf).
module blk_alloc_client #(
    parameter int AWIDTH     = 10,
    parameter int POOL_DEPTH = 4,
    parameter int REL_DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rst,
    blk_alloc_client_if.master bus
);
    localparam int PAW = $clog2(POOL_DEPTH);
    localparam int PCW = PAW + 1;
    localparam int RAW = $clog2(REL_DEPTH);
    localparam int RCW = RAW + 1;

    typedef enum logic {S_IDLE, S_REQ} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_cap;
    logic              w_pop;

    logic [AWIDTH-1:0] r_pool [POOL_DEPTH];
    logic [PAW-1:0]    r_pool_wp;
    logic [PAW-1:0]    r_pool_rp;
    logic [PCW-1:0]    r_pool_cnt;

    logic [AWIDTH-1:0] r_rq [REL_DEPTH];
    logic [RAW-1:0]    r_rq_wp;
    logic [RAW-1:0]    r_rq_rp;
    logic [RCW-1:0]    r_rq_cnt;
    logic [RCW-1:0]    w_rq_free;
    logic              w_acc_a;
    logic              w_acc_b;
    logic              w_drain;
    logic [AWIDTH-1:0] w_head;
    logic              r_rls_vld;
    logic [AWIDTH-1:0] r_rls_addr;
    logic              r_rel_ovf;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Once raised, the request is held until granted regardless of en/mgr_full.
    always_comb begin
        w_state_nxt = r_state;
        w_cap       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.en && !bus.mgr_full && (r_pool_cnt < PCW'(POOL_DEPTH))) begin
                    w_state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                if (bus.ocp_vld) begin
                    w_cap       = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign bus.ocp_req = (r_state == S_REQ);

    always_ff @(posedge clk) begin
        if (!rst && w_cap) begin
            assert (bus.ocp_rsp);
        end
    end

    assign w_pop = bus.blk_pop && (r_pool_cnt != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pool_wp  <= '0;
            r_pool_rp  <= '0;
            r_pool_cnt <= '0;
        end else begin
            if (w_cap) begin
                r_pool[r_pool_wp] <= bus.ocp_block_addr;
                r_pool_wp         <= r_pool_wp + 1'b1;
            end
            if (w_pop) begin
                r_pool_rp <= r_pool_rp + 1'b1;
            end
            case ({w_cap, w_pop})
                2'b10:   r_pool_cnt <= r_pool_cnt + 1'b1;
                2'b01:   r_pool_cnt <= r_pool_cnt - 1'b1;
                default: r_pool_cnt <= r_pool_cnt;
            endcase
        end
    end

    assign bus.blk_vld  = (r_pool_cnt != '0);
    assign bus.blk_addr = (r_pool_cnt != '0) ? r_pool[r_pool_rp] : '0;
    assign bus.pool_cnt = r_pool_cnt;

    // The slot drained this cycle counts as free; with an empty queue the first
    // accepted push is forwarded straight into the output register.
    always_comb begin
        w_rq_free = RCW'(REL_DEPTH) - r_rq_cnt + ((r_rq_cnt != '0) ? RCW'(1) : RCW'(0));
        w_acc_a   = bus.rel_push_a && (w_rq_free != '0);
        w_acc_b   = bus.rel_push_b && (w_rq_free > RCW'(w_acc_a));
        w_drain   = (r_rq_cnt != '0) || w_acc_a || w_acc_b;
        if (r_rq_cnt != '0) begin
            w_head = r_rq[r_rq_rp];
        end else if (w_acc_a) begin
            w_head = bus.rel_addr_a;
        end else begin
            w_head = bus.rel_addr_b;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rq_wp    <= '0;
            r_rq_rp    <= '0;
            r_rq_cnt   <= '0;
            r_rls_vld  <= 1'b0;
            r_rls_addr <= '0;
            r_rel_ovf  <= 1'b0;
        end else begin
            if (w_acc_a) begin
                r_rq[r_rq_wp] <= bus.rel_addr_a;
            end
            if (w_acc_b) begin
                r_rq[r_rq_wp + RAW'(w_acc_a)] <= bus.rel_addr_b;
            end
            r_rq_wp <= r_rq_wp + RAW'(w_acc_a) + RAW'(w_acc_b);
            if (w_drain) begin
                r_rq_rp <= r_rq_rp + 1'b1;
            end
            r_rq_cnt   <= r_rq_cnt + RCW'(w_acc_a) + RCW'(w_acc_b) - RCW'(w_drain);
            r_rls_vld  <= w_drain;
            r_rls_addr <= w_drain ? w_head : '0;
            if ((bus.rel_push_a && !w_acc_a) || (bus.rel_push_b && !w_acc_b)) begin
                r_rel_ovf <= 1'b1;
            end
        end
    end

    assign bus.rls_vld        = r_rls_vld;
    assign bus.rls_block_addr = r_rls_addr;
    assign bus.rel_ovf        = r_rel_ovf;
    assign bus.rel_ready      = (r_rq_cnt <= RCW'(REL_DEPTH - 2));

endmodule

// File: tb/tb_blk_alloc_client.sv
// Directed + randomized bench for blk_alloc_client against a queue-based reference model.
`timescale 1ns/1ps
module tb_blk_alloc_client;
    localparam int AW = 10;
    localparam int PD = 4;
    localparam int RD = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    blk_alloc_client_if #(.AWIDTH(AW), .POOL_DEPTH(PD)) bus ();

    blk_alloc_client #(.AWIDTH(AW), .POOL_DEPTH(PD), .REL_DEPTH(RD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Manager model controls
    logic [AW-1:0] grant_q[$];
    bit            mgr_hold = 1'b0;
    bit            spur     = 1'b0;
    int            req_cnt  = 0;

    // Reference model state
    logic [AW-1:0] m_pool[$];
    logic [AW-1:0] m_rq[$];
    bit            m_out      = 1'b0;
    bit            m_ovf      = 1'b0;
    bit            m_rls_vld  = 1'b0;
    logic [AW-1:0] m_rls_addr = '0;
    int            m_psz;
    int            m_free;

    always @(posedge clk) begin
        if (rst) begin
            m_pool.delete();
            m_rq.delete();
            m_out      = 1'b0;
            m_ovf      = 1'b0;
            m_rls_vld  = 1'b0;
            m_rls_addr = '0;
        end else begin
            m_psz = m_pool.size();
            if (bus.blk_pop && m_psz > 0) void'(m_pool.pop_front());
            if (m_out) begin
                if (bus.ocp_vld) begin
                    m_pool.push_back(bus.ocp_block_addr);
                    m_out = 1'b0;
                end
            end else if (bus.en && !bus.mgr_full && m_psz < PD) begin
                m_out = 1'b1;
            end
            m_free = RD - m_rq.size() + ((m_rq.size() != 0) ? 1 : 0);
            if (bus.rel_push_a) begin
                if (m_free > 0) begin m_rq.push_back(bus.rel_addr_a); m_free--; end
                else m_ovf = 1'b1;
            end
            if (bus.rel_push_b) begin
                if (m_free > 0) begin m_rq.push_back(bus.rel_addr_b); m_free--; end
                else m_ovf = 1'b1;
            end
            if (m_rq.size() > 0) begin
                m_rls_vld  = 1'b1;
                m_rls_addr = m_rq.pop_front();
            end else begin
                m_rls_vld  = 1'b0;
                m_rls_addr = '0;
            end
        end
    end

    // Manager: grants after the request has been seen for 2 cycles
    initial begin
        bus.ocp_vld        = 1'b0;
        bus.ocp_rsp        = 1'b0;
        bus.ocp_block_addr = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                req_cnt     = 0;
                bus.ocp_vld = 1'b0;
                bus.ocp_rsp = 1'b0;
            end else if (bus.ocp_vld) begin
                bus.ocp_vld = 1'b0;
                bus.ocp_rsp = 1'b0;
                req_cnt     = 0;
            end else if (spur && !bus.ocp_req) begin
                bus.ocp_vld        = 1'b1;
                bus.ocp_rsp        = 1'b1;
                bus.ocp_block_addr = AW'(999);
                spur               = 1'b0;
            end else if (bus.ocp_req) begin
                req_cnt++;
                if (req_cnt >= 2 && !mgr_hold && grant_q.size() > 0) begin
                    bus.ocp_vld        = 1'b1;
                    bus.ocp_rsp        = 1'b1;
                    bus.ocp_block_addr = grant_q.pop_front();
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("ocp_req", 32'(bus.ocp_req), 32'(m_out));
        chk("blk_vld", 32'(bus.blk_vld), 32'(m_pool.size() != 0));
        chk("blk_addr", 32'(bus.blk_addr), (m_pool.size() != 0) ? 32'(m_pool[0]) : 32'd0);
        chk("pool_cnt", 32'(bus.pool_cnt), 32'(m_pool.size()));
        chk("rls_vld", 32'(bus.rls_vld), 32'(m_rls_vld));
        chk("rls_addr", 32'(bus.rls_block_addr), 32'(m_rls_addr));
        chk("rel_ovf", 32'(bus.rel_ovf), 32'(m_ovf));
        chk("rel_ready", 32'(bus.rel_ready), 32'((RD - m_rq.size()) >= 2));
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        check_all();
        bus.blk_pop    = 1'b0;
        bus.rel_push_a = 1'b0;
        bus.rel_push_b = 1'b0;
    endtask

    int  pulses;
    bit  prev;

    initial begin
        rst            = 1'b1;
        bus.en         = 1'b0;
        bus.mgr_full   = 1'b0;
        bus.blk_pop    = 1'b0;
        bus.rel_push_a = 1'b0;
        bus.rel_push_b = 1'b0;
        bus.rel_addr_a = '0;
        bus.rel_addr_b = '0;
        @(negedge clk);
        step();
        step();
        chk("rst_ocp_req", 32'(bus.ocp_req), 32'd0);
        chk("rst_blk_addr", 32'(bus.blk_addr), 32'd0);
        chk("rst_rls_addr", 32'(bus.rls_block_addr), 32'd0);
        chk("rst_rel_ready", 32'(bus.rel_ready), 32'd1);
        rst = 1'b0;

        // Fill the pool with 5..8
        grant_q.push_back(AW'(5)); grant_q.push_back(AW'(6));
        grant_q.push_back(AW'(7)); grant_q.push_back(AW'(8));
        bus.en = 1'b1;
        pulses = 0;
        prev   = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (bus.ocp_req && !prev) pulses++;
            prev = bus.ocp_req;
        end
        chk("req_pulses", 32'(pulses), 32'd4);
        chk("fill_cnt", 32'(bus.pool_cnt), 32'd4);
        chk("fill_head", 32'(bus.blk_addr), 32'd5);
        chk("fill_req_idle", 32'(bus.ocp_req), 32'd0);

        // Two pops; refill request follows the first pop by one cycle
        grant_q.push_back(AW'(20)); grant_q.push_back(AW'(21));
        bus.blk_pop = 1'b1;
        step();
        chk("pop1_head", 32'(bus.blk_addr), 32'd6);
        chk("pop1_cnt", 32'(bus.pool_cnt), 32'd3);
        chk("pop1_req", 32'(bus.ocp_req), 32'd0);
        bus.blk_pop = 1'b1;
        step();
        chk("pop2_head", 32'(bus.blk_addr), 32'd7);
        chk("pop2_cnt", 32'(bus.pool_cnt), 32'd2);
        chk("pop2_req", 32'(bus.ocp_req), 32'd1);
        for (int i = 0; i < 10; i++) step();

        // Manager full with an empty pool
        bus.mgr_full = 1'b1;
        for (int i = 0; i < 6; i++) step();
        for (int i = 0; i < 6; i++) begin bus.blk_pop = 1'b1; step(); end
        grant_q.delete();
        for (int i = 0; i < 3; i++) step();
        chk("full_req", 32'(bus.ocp_req), 32'd0);
        chk("full_blk_vld", 32'(bus.blk_vld), 32'd0);
        bus.mgr_full = 1'b0;
        step();
        chk("unfull_req", 32'(bus.ocp_req), 32'd1);
        grant_q.push_back(AW'(12));
        step();
        step();
        chk("grant12_addr", 32'(bus.blk_addr), 32'd12);
        chk("grant12_vld", 32'(bus.blk_vld), 32'd1);

        // Release ordering: A before B, then A
        bus.rel_push_a = 1'b1; bus.rel_addr_a = AW'(3);
        bus.rel_push_b = 1'b1; bus.rel_addr_b = AW'(9);
        step();
        chk("rls_first", 32'(bus.rls_block_addr), 32'd3);
        bus.rel_push_a = 1'b1; bus.rel_addr_a = AW'(4);
        step();
        chk("rls_second", 32'(bus.rls_block_addr), 32'd9);
        step();
        chk("rls_third", 32'(bus.rls_block_addr), 32'd4);
        chk("rls_third_vld", 32'(bus.rls_vld), 32'd1);
        step();
        chk("rls_idle", 32'(bus.rls_vld), 32'd0);
        chk("rls_no_ovf", 32'(bus.rel_ovf), 32'd0);

        // Saturate the release queue
        for (int i = 0; i < 10; i++) begin
            bus.rel_push_a = 1'b1; bus.rel_addr_a = AW'($urandom);
            bus.rel_push_b = 1'b1; bus.rel_addr_b = AW'($urandom);
            step();
        end
        chk("sat_ovf", 32'(bus.rel_ovf), 32'd1);
        chk("sat_ready", 32'(bus.rel_ready), 32'd0);
        for (int i = 0; i < 10; i++) step();
        chk("sat_drained", 32'(bus.rls_vld), 32'd0);

        // Stray address strobe while idle is ignored
        grant_q.push_back(AW'(77));
        for (int i = 0; i < 4; i++) step();
        bus.en = 1'b0;
        for (int i = 0; i < 4; i++) step();
        spur = 1'b1;
        for (int i = 0; i < 3; i++) step();
        chk("spur_ignored", 32'(bus.pool_cnt), 32'd2);

        // Randomized traffic
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 400; i++) begin
            bus.en         = ($urandom_range(0, 7) != 0);
            bus.mgr_full   = ($urandom_range(0, 5) == 0);
            bus.blk_pop    = ($urandom_range(0, 2) == 0);
            bus.rel_push_a = ($urandom_range(0, 1) == 0);
            bus.rel_addr_a = AW'($urandom);
            bus.rel_push_b = ($urandom_range(0, 2) == 0);
            bus.rel_addr_b = AW'($urandom);
            mgr_hold       = ($urandom_range(0, 3) == 0);
            if (grant_q.size() < 2) grant_q.push_back(AW'($urandom));
            step();
        end
        mgr_hold = 1'b0;

        // Reset while a request is outstanding
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.en       = 1'b1;
        bus.mgr_full = 1'b0;
        grant_q.delete();
        grant_q.push_back(AW'(40)); grant_q.push_back(AW'(41));
        for (int i = 0; i < 30 && m_pool.size() != 2; i++) step();
        for (int i = 0; i < 3; i++) step();
        chk("pre_rst_req", 32'(bus.ocp_req), 32'd1);
        chk("pre_rst_cnt", 32'(bus.pool_cnt), 32'd2);
        rst = 1'b1;
        step();
        chk("rst_req", 32'(bus.ocp_req), 32'd0);
        chk("rst_cnt", 32'(bus.pool_cnt), 32'd0);
        chk("rst_blk_vld", 32'(bus.blk_vld), 32'd0);
        chk("rst_rls_vld", 32'(bus.rls_vld), 32'd0);
        rst = 1'b0;
        grant_q.push_back(AW'(50));
        for (int i = 0; i < 5; i++) step();
        chk("restart_addr", 32'(bus.blk_addr), 32'd50);
        chk("restart_cnt", 32'(bus.pool_cnt), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
